// File: rtl/code_lock_pkg.sv
// code_lock_pkg: shared definitions for the serial code-lock controller.
//   state_e  - controller state encoding (collect, check, open, lockout)
//   TIMER_W  - width of the shared open/lockout down-counter
package code_lock_pkg;

  typedef enum logic [1:0] {
    S_COLLECT = 2'b00,
    S_CHECK   = 2'b01,
    S_OPEN    = 2'b10,
    S_LOCKOUT = 2'b11
  } state_e;

  localparam int unsigned TIMER_W = 16;

endpackage

// File: rtl/code_lock_ctrl_cycle_timer.sv
// cycle_timer: loadable down-counter that stops at zero.
//   clock, reset - system clock, asynchronous active-high reset
//   load         - load load_value (has priority over en)
//   load_value   - value to load
//   en           - decrement by one while the count is non-zero
//   zero         - count is zero
module cycle_timer
  import code_lock_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_value,
  input  logic               en,
  output logic               zero
);

  logic [TIMER_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - TIMER_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/code_lock_ctrl.sv
// code_lock_ctrl: serial code-lock controller (Moore FSM).
// Collects CODE_LEN serial bits (first bit lands in the MSB), compares them
// with KEY, holds unlock for OPEN_CYCLES cycles on a match and counts
// consecutive failures. With CODE_LOCK_LOCKOUT_EN defined, MAX_TRIES
// consecutive failures raise alarm for LOCKOUT_CYCLES cycles; without it
// the lockout state and failure counter are absent, alarm and fails are 0.
//   clock, reset - system clock, asynchronous active-high reset
//   bit_valid    - code is valid this cycle
//   code         - serial code bit
//   clear        - abort the partial entry (wins over bit_valid)
//   ready        - accepting bits
//   unlock       - code accepted, lock open
//   alarm        - lockout active
//   fails        - consecutive-failure count
module code_lock_ctrl
  import code_lock_pkg::*;
#(
  parameter int unsigned          CODE_LEN       = 4,
  parameter logic [CODE_LEN-1:0]  KEY            = 4'b0110,
  parameter int unsigned          MAX_TRIES      = 3,
  parameter int unsigned          OPEN_CYCLES    = 8,
  parameter int unsigned          LOCKOUT_CYCLES = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       bit_valid,
  input  logic       code,
  input  logic       clear,
  output logic       ready,
  output logic       unlock,
  output logic       alarm,
  output logic [3:0] fails
);

  localparam int unsigned CNT_W = $clog2(CODE_LEN);

  if (CODE_LEN < 2 || CODE_LEN > 16) begin : g_bad_code_len
    $error("CODE_LEN must be 2..16");
  end
  if (MAX_TRIES < 1 || MAX_TRIES > 15) begin : g_bad_max_tries
    $error("MAX_TRIES must be 1..15");
  end
  if (OPEN_CYCLES < 1 || LOCKOUT_CYCLES < 1) begin : g_bad_cycles
    $error("OPEN_CYCLES and LOCKOUT_CYCLES must be >= 1");
  end

  state_e              state_q, state_d;
  logic [CODE_LEN-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]    bitcnt_q, bitcnt_d;
  logic                tmr_load, tmr_en, tmr_zero;
  logic [TIMER_W-1:0]  tmr_value;
`ifdef CODE_LOCK_LOCKOUT_EN
  logic [3:0]          fails_q, fails_d;
`endif

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bitcnt_d  = bitcnt_q;
`ifdef CODE_LOCK_LOCKOUT_EN
    fails_d   = fails_q;
`endif
    tmr_load  = 1'b0;
    tmr_value = '0;
    tmr_en    = 1'b0;
    case (state_q)
      S_COLLECT: begin
        if (clear) begin
          shift_d  = '0;
          bitcnt_d = '0;
        end else if (bit_valid) begin
          shift_d = {shift_q[CODE_LEN-2:0], code};
          if (bitcnt_q == CNT_W'(CODE_LEN - 1)) begin
            bitcnt_d = '0;
            state_d  = S_CHECK;
          end else begin
            bitcnt_d = bitcnt_q + CNT_W'(1);
          end
        end
      end
      S_CHECK: begin
        if (shift_q == KEY) begin
          state_d   = S_OPEN;
          tmr_load  = 1'b1;
          tmr_value = TIMER_W'(OPEN_CYCLES - 1);
`ifdef CODE_LOCK_LOCKOUT_EN
          fails_d   = '0;
        end else if (({1'b0, fails_q} + 5'd1) == 5'(MAX_TRIES)) begin
          state_d   = S_LOCKOUT;
          tmr_load  = 1'b1;
          tmr_value = TIMER_W'(LOCKOUT_CYCLES - 1);
          fails_d   = 4'(MAX_TRIES);
        end else begin
          state_d   = S_COLLECT;
          fails_d   = (fails_q == '1) ? fails_q : fails_q + 4'd1;
        end
`else
        end else begin
          state_d   = S_COLLECT;
        end
`endif
      end
      S_OPEN: begin
        tmr_en = 1'b1;
        if (tmr_zero) begin
          state_d = S_COLLECT;
        end
      end
`ifdef CODE_LOCK_LOCKOUT_EN
      S_LOCKOUT: begin
        tmr_en = 1'b1;
        if (tmr_zero) begin
          state_d = S_COLLECT;
          fails_d = '0;
        end
      end
`endif
      default: state_d = S_COLLECT;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_COLLECT;
      shift_q  <= '0;
      bitcnt_q <= '0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      bitcnt_q <= bitcnt_d;
    end
  end

  cycle_timer u_timer (
    .clock      (clock),
    .reset      (reset),
    .load       (tmr_load),
    .load_value (tmr_value),
    .en         (tmr_en),
    .zero       (tmr_zero)
  );

  assign ready  = (state_q == S_COLLECT);
  assign unlock = (state_q == S_OPEN);

`ifdef CODE_LOCK_LOCKOUT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fails_q <= '0;
    end else begin
      fails_q <= fails_d;
    end
  end

  assign alarm = (state_q == S_LOCKOUT);
  assign fails = fails_q;
`else
  assign alarm = 1'b0;
  assign fails = '0;
`endif

endmodule
